// File: rtl/my_timer_pkg.sv
// Shared helpers for the period timer.
// Full-scale DAC codes and the enable-bit position of the GPIO control word
// are functions of the configured widths, so they live here for the core and
// the tick generator.
package my_timer_pkg;

  // Bit position of EN inside a control word of the given width.
  function automatic int unsigned en_bit(input int unsigned width);
    return width - 1;
  endfunction

  // Most positive two's complement code of a width-bit DAC (e.g. 0x1FFF at 14 bits).
  function automatic logic [31:0] dac_pos_fs(input int unsigned width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

  // Most negative two's complement code of a width-bit DAC (e.g. 0x2000 at 14 bits).
  function automatic logic [31:0] dac_neg_fs(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/my_timer_tick_gen.sv
// Tick generator: captures the GPIO control word, decodes whether the timer
// is active and runs the period counter.
//   clk    : timer clock, rising edge
//   rst    : asynchronous active-high reset
//   gp_in  : raw control word {EN, N}
//   active : EN set and N non-zero (from the captured word)
//   tick   : one-cycle pulse on the edge where the period expires
//   cnt    : live counter value
module my_timer_tick_gen
  import my_timer_pkg::*;
#(
  parameter int GPIO_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [GPIO_WIDTH-1:0] gp_in,
  output logic                  active,
  output logic                  tick,
  output logic [GPIO_WIDTH-2:0] cnt
);

  localparam int EN = int'(en_bit(GPIO_WIDTH));
  localparam int CW = GPIO_WIDTH - 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [GPIO_WIDTH-1:0] gp_q, gp_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         period;

  always_comb begin
    gp_d   = gp_in;
    period = gp_q[CW-1:0];
    active = gp_q[EN] && (period != '0);
    // >= rather than == so a period shortened below the current count
    // expires on the very next edge instead of running to wrap-around.
    tick   = active && (cnt_q >= (period - CNT_ONE));
    cnt_d  = '0;
    if (active && !tick) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gp_q  <= '0;
      cnt_q <= '0;
    end else begin
      gp_q  <= gp_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/my_timer_core.sv
// Programmable period timer between the PS GPIO block and the dual DAC path.
// Each period expiry toggles a full-scale square wave on DAC A and steps a
// sawtooth on DAC B; the completed-period count and live counter are read
// back over GPIO.
//   ADC_CLK   : sole clock, rising edge
//   RST       : asynchronous active-high reset
//   GP_IN     : control word {EN, N}, N = period in ADC_CLK cycles
//   DAC_A_OUT : square wave, two's complement
//   DAC_B_OUT : sawtooth, two's complement
//   val_0     : completed-period count (held while disabled)
//   val_1     : live cycle counter, zero-extended
module my_timer_core
  import my_timer_pkg::*;
#(
  parameter int GPIO_WIDTH = 32,
  parameter int DAC_WIDTH  = 14
) (
  input  logic                        ADC_CLK,
  input  logic                        RST,
  input  logic [GPIO_WIDTH-1:0]       GP_IN,
  output logic signed [DAC_WIDTH-1:0] DAC_A_OUT,
  output logic signed [DAC_WIDTH-1:0] DAC_B_OUT,
  output logic [GPIO_WIDTH-1:0]       val_0,
  output logic [GPIO_WIDTH-1:0]       val_1
);

  localparam logic signed [DAC_WIDTH-1:0] POS_FS = DAC_WIDTH'(dac_pos_fs(DAC_WIDTH));
  localparam logic signed [DAC_WIDTH-1:0] NEG_FS = DAC_WIDTH'(dac_neg_fs(DAC_WIDTH));
  localparam logic [DAC_WIDTH-1:0]        SAW_ONE = DAC_WIDTH'(1);
  localparam logic [GPIO_WIDTH-1:0]       VAL_ONE = GPIO_WIDTH'(1);

  logic                  active;
  logic                  tick;
  logic [GPIO_WIDTH-2:0] cnt;

  my_timer_tick_gen #(
    .GPIO_WIDTH (GPIO_WIDTH)
  ) u_tick_gen (
    .clk    (ADC_CLK),
    .rst    (RST),
    .gp_in  (GP_IN),
    .active (active),
    .tick   (tick),
    .cnt    (cnt)
  );

  logic                        phase_q, phase_d;
  logic [DAC_WIDTH-1:0]        saw_q, saw_d;
  logic [GPIO_WIDTH-1:0]       val0_q, val0_d;
  logic signed [DAC_WIDTH-1:0] dac_a_q, dac_a_d;
  logic signed [DAC_WIDTH-1:0] dac_b_q, dac_b_d;

  always_comb begin
    phase_d = phase_q;
    saw_d   = saw_q;
    val0_d  = val0_q;
    dac_a_d = '0;
    dac_b_d = '0;
    if (!active) begin
      // Waveform state restarts from phase 0 / sawtooth 0 on re-enable;
      // the period count is deliberately kept.
      phase_d = 1'b0;
      saw_d   = '0;
    end else begin
      if (tick) begin
        phase_d = ~phase_q;
        saw_d   = saw_q + SAW_ONE;
        val0_d  = val0_q + VAL_ONE;
      end
      // DACs present the current waveform state, so the first active edge
      // always shows +FS and sawtooth 0.
      dac_a_d = phase_q ? NEG_FS : POS_FS;
      dac_b_d = saw_q;
    end
  end

  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) begin
      phase_q <= 1'b0;
      saw_q   <= '0;
      val0_q  <= '0;
      dac_a_q <= '0;
      dac_b_q <= '0;
    end else begin
      phase_q <= phase_d;
      saw_q   <= saw_d;
      val0_q  <= val0_d;
      dac_a_q <= dac_a_d;
      dac_b_q <= dac_b_d;
    end
  end

  assign DAC_A_OUT = dac_a_q;
  assign DAC_B_OUT = dac_b_q;
  assign val_0     = val0_q;
  assign val_1     = {1'b0, cnt};

endmodule

// File: tb/tb_my_timer_core.sv
module tb_my_timer_core;

  logic        clk;
  logic        rst;
  logic [31:0] gp_in;
  logic [13:0] dac_a;
  logic [13:0] dac_b;
  logic [31:0] val_0;
  logic [31:0] val_1;

  my_timer_core #(
    .GPIO_WIDTH (32),
    .DAC_WIDTH  (14)
  ) dut (
    .ADC_CLK   (clk),
    .RST       (rst),
    .GP_IN     (gp_in),
    .DAC_A_OUT (dac_a),
    .DAC_B_OUT (dac_b),
    .val_0     (val_0),
    .val_1     (val_1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [13:0] POS = 14'h1FFF;
  localparam logic [13:0] NEG = 14'h2000;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: tracks ticks since the timer last became active; the
  // square-wave phase is the tick count's parity and the sawtooth is the
  // tick count modulo 2^14. DAC outputs show the state from before the edge.
  logic [31:0] m_gp;
  longint      m_cnt;
  longint      m_ticks;
  logic [31:0] m_val0;
  logic [13:0] m_a;
  logic [13:0] m_b;

  task automatic model_reset();
    m_gp = 0; m_cnt = 0; m_ticks = 0; m_val0 = 0; m_a = 0; m_b = 0;
  endtask

  task automatic model_step(input logic [31:0] g);
    longint n;
    bit     act;
    n   = longint'(m_gp[30:0]);
    act = m_gp[31] && (n != 0);
    if (act) begin
      m_a = (m_ticks % 2 == 1) ? NEG : POS;
      m_b = 14'(m_ticks % 16384);
      if (m_cnt >= n - 1) begin
        m_cnt = 0;
        m_ticks++;
        m_val0 = m_val0 + 1;
      end else begin
        m_cnt++;
      end
    end else begin
      m_a = 0; m_b = 0; m_cnt = 0; m_ticks = 0;
    end
    m_gp = g;
  endtask

  task automatic run_cycle(input logic [31:0] g, input bit cmp);
    gp_in = g;
    @(posedge clk);
    model_step(g);
    #1;
    if (cmp) begin
      check("model dac_a", 32'(dac_a), 32'(m_a));
      check("model dac_b", 32'(dac_b), 32'(m_b));
      check("model val_0", val_0, m_val0);
      check("model val_1", val_1, 32'(m_cnt));
    end
  endtask

  typedef struct {
    logic [31:0] gp;
    int          cycles;
    logic [13:0] a;
    logic [13:0] b;
    logic [31:0] v0;
    logic [31:0] v1;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] v0_save;
    logic [13:0] prev_b;
    bit          seen_wrap;
    bit          found;
    logic [31:0] g;

    vecs[0]  = '{32'h8000_0020,  1, 14'h0000, 14'h0000, 32'd0, 32'd0};
    vecs[1]  = '{32'h8000_0020,  1, POS,      14'h0000, 32'd0, 32'd1};
    vecs[2]  = '{32'h8000_0020, 30, POS,      14'h0000, 32'd0, 32'd31};
    vecs[3]  = '{32'h8000_0020,  1, POS,      14'h0000, 32'd1, 32'd0};
    vecs[4]  = '{32'h8000_0020,  1, NEG,      14'h0001, 32'd1, 32'd1};
    vecs[5]  = '{32'h8000_0020, 32, POS,      14'h0002, 32'd2, 32'd1};
    vecs[6]  = '{32'h0000_0020,  1, POS,      14'h0002, 32'd2, 32'd2};
    vecs[7]  = '{32'h0000_0020,  1, 14'h0000, 14'h0000, 32'd2, 32'd0};
    vecs[8]  = '{32'h8000_0020,  1, 14'h0000, 14'h0000, 32'd2, 32'd0};
    vecs[9]  = '{32'h8000_0020,  1, POS,      14'h0000, 32'd2, 32'd1};
    vecs[10] = '{32'h8000_0001,  1, POS,      14'h0000, 32'd2, 32'd2};
    vecs[11] = '{32'h8000_0001,  1, POS,      14'h0000, 32'd3, 32'd0};
    vecs[12] = '{32'h8000_0001,  1, NEG,      14'h0001, 32'd4, 32'd0};
    vecs[13] = '{32'h8000_0001,  1, POS,      14'h0002, 32'd5, 32'd0};
    vecs[14] = '{32'h8000_0000,  1, NEG,      14'h0003, 32'd6, 32'd0};
    vecs[15] = '{32'h8000_0000,  3, 14'h0000, 14'h0000, 32'd6, 32'd0};

    // Reset state
    rst   = 1'b1;
    gp_in = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset dac_a", 32'(dac_a), 32'h0);
    check("reset dac_b", 32'(dac_b), 32'h0);
    check("reset val_0", val_0, 32'h0);
    check("reset val_1", val_1, 32'h0);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      gp_in = vecs[i].gp;
      repeat (vecs[i].cycles) @(posedge clk);
      #1;
      check($sformatf("vec%0d dac_a", i), 32'(dac_a), 32'(vecs[i].a));
      check($sformatf("vec%0d dac_b", i), 32'(dac_b), 32'(vecs[i].b));
      check($sformatf("vec%0d val_0", i), val_0, vecs[i].v0);
      check($sformatf("vec%0d val_1", i), val_1, vecs[i].v1);
    end

    // Asynchronous reset mid-run, between clock edges
    gp_in = 32'h8000_0001;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async rst dac_a", 32'(dac_a), 32'h0);
    check("async rst dac_b", 32'(dac_b), 32'h0);
    check("async rst val_0", val_0, 32'h0);
    check("async rst val_1", val_1, 32'h0);
    gp_in = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Period shrink: count to 20 at N=32, then write N=8
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      run_cycle(32'h8000_0020, 1'b1);
      if (val_1 == 32'd20) found = 1'b1;
    end
    check("shrink reach cnt20", 32'(found), 32'd1);
    v0_save = val_0;
    run_cycle(32'h8000_0008, 1'b1);
    check("shrink capture val_1", val_1, 32'd21);
    run_cycle(32'h8000_0008, 1'b1);
    check("shrink tick val_1", val_1, 32'd0);
    check("shrink tick val_0", val_0, v0_save + 32'd1);
    repeat (7) run_cycle(32'h8000_0008, 1'b1);
    check("shrink mid val_1", val_1, 32'd7);
    check("shrink mid val_0", val_0, v0_save + 32'd1);
    run_cycle(32'h8000_0008, 1'b1);
    check("shrink 2nd tick val_1", val_1, 32'd0);
    check("shrink 2nd tick val_0", val_0, v0_save + 32'd2);

    // Sawtooth wrap at N=1
    seen_wrap = 1'b0;
    prev_b    = dac_b;
    for (int i = 0; i < 16400; i++) begin
      run_cycle(32'h8000_0001, 1'b1);
      if (prev_b == 14'h3FFF && dac_b == 14'h0000) seen_wrap = 1'b1;
      prev_b = dac_b;
    end
    check("sawtooth wrap seen", 32'(seen_wrap), 32'd1);

    // Randomized control words against the model
    g = 32'h8000_0005;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        g[31]   = ($urandom_range(0, 3) != 0);
        g[30:0] = ($urandom_range(0, 3) == 0) ? 31'($urandom_range(0, 40))
                                              : 31'($urandom_range(0, 6));
      end
      run_cycle(g, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
